// File: rtl/mem_dbus_stage_pkg.sv
// Shared constants and state type for the memory-access stage and its lane aligner.
package mem_dbus_stage_pkg;

    localparam int unsigned STALL_W      = 6;
    localparam int unsigned BSEL_W       = 4;
    localparam logic        NOSTOP       = 1'b0;

    localparam logic [1:0]  SIZE_B       = 2'b00;
    localparam logic [1:0]  SIZE_H       = 2'b01;
    localparam logic [1:0]  SIZE_W       = 2'b10;

    localparam logic [4:0]  EXC_NONE     = 5'h00;
    localparam logic [4:0]  EXC_ADEL     = 5'h04;
    localparam logic [4:0]  EXC_ADES     = 5'h05;
    localparam logic [4:0]  EXC_DBE      = 5'h07;

    localparam int unsigned DBUS_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } dbus_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane decode: access size + low address bits -> byte enables,
// lane-replicated store data and misalignment flags.
module mem_lane_align
    import mem_dbus_stage_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_misalign_h,
    output logic        o_misalign_w
);

    always_comb begin
        o_be         = 4'b1111;
        o_wdata      = i_wdata;
        o_misalign_h = 1'b0;
        o_misalign_w = 1'b0;
        case (i_size)
            SIZE_B: begin
                o_be    = 4'b0001 << i_addr;
                o_wdata = {4{i_wdata[7:0]}};
            end
            SIZE_H: begin
                o_be         = i_addr[1] ? 4'b1100 : 4'b0011;
                o_wdata      = {2{i_wdata[15:0]}};
                o_misalign_h = i_addr[0];
            end
            SIZE_W, 2'b11: begin
                o_misalign_w = |i_addr;
            end
        endcase
    end

endmodule

// File: rtl/mem_dbus_stage.sv
// MEM stage: turns EX/MEM load/store requests into a registered req/ack bus transaction.
// Optional ack timeout (bus error 0x07) is built when DBUS_TIMEOUT_EN is defined.
module mem_dbus_stage
    import mem_dbus_stage_pkg::*;
#(
    parameter int unsigned BUS_AW         = 32,
    parameter int unsigned TIMEOUT_CYCLES = DBUS_TIMEOUT
) (
    input  logic               cpu_clk_50M,
    input  logic               cpu_rst_n,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               exmem_re,
    input  logic               exmem_we,
    input  logic [1:0]         exmem_size,
    input  logic               exmem_sign,
    input  logic [31:0]        exmem_addr,
    input  logic [31:0]        exmem_wdata,
    input  logic [4:0]         exmem_wa,
    input  logic               exmem_wreg,
    input  logic [31:0]        exmem_dreg,
    input  logic               exmem_whilo,
    input  logic [63:0]        exmem_hilo,
    input  logic               exmem_cp0_we,
    input  logic [4:0]         exmem_cp0_waddr,
    input  logic [31:0]        exmem_cp0_wdata,
    output logic [4:0]         mem_wa,
    output logic               mem_wreg,
    output logic [31:0]        mem_dreg,
    output logic               mem_whilo,
    output logic [63:0]        mem_hilo,
    output logic               mem_cp0_we,
    output logic [4:0]         mem_cp0_waddr,
    output logic [31:0]        mem_cp0_wdata,
    output logic               mem_mreg,
    output logic [BSEL_W-1:0]  mem_dre,
    output logic [31:0]        mem_daddr,
    output logic [31:0]        mem_dm,
    output logic               mem_sign,
    output logic [4:0]         mem_exccode,
    output logic [31:0]        mem_badvaddr,
    output logic               stall_req_mem,
    output logic               dbus_req,
    output logic               dbus_wr,
    output logic [BUS_AW-1:0]  dbus_addr,
    output logic [3:0]         dbus_be,
    output logic [31:0]        dbus_wdata,
    input  logic [31:0]        dbus_rdata,
    input  logic               dbus_ack
);

    dbus_state_t       r_state, w_state_nxt;
    logic              r_req, r_wr, r_tmo;
    logic [BUS_AW-1:0] r_addr;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata, r_rdata;

    logic [3:0]  w_be;
    logic [31:0] w_wdata_rep, w_addr_al;
    logic        w_mis_h, w_mis_w, w_access, w_mis, w_go, w_dbe, w_tmo_hit;
    logic        w_unused;

    mem_lane_align u_lane (
        .i_size       (exmem_size),
        .i_addr       (exmem_addr[1:0]),
        .i_wdata      (exmem_wdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata_rep),
        .o_misalign_h (w_mis_h),
        .o_misalign_w (w_mis_w)
    );

    assign w_access  = exmem_re | exmem_we;
    assign w_mis     = w_access & (w_mis_h | w_mis_w);
    assign w_go      = w_access & ~w_mis;
    assign w_addr_al = {exmem_addr[31:2], 2'b00};
    assign w_dbe     = (r_state == ST_DONE) & r_tmo;
    assign w_unused  = ^{stall[STALL_W-1:5], stall[3:0]};

`ifdef DBUS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             w_waiting;

    assign w_waiting = (r_state == ST_BUSY) || (r_state == ST_DRAIN);
    assign w_tmo_hit = w_waiting && !dbus_ack && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n || !w_waiting) r_cnt <= '0;
        else                          r_cnt <= r_cnt + 1'b1;
    end
`else
    logic w_unused_tmo;
    assign w_tmo_hit    = 1'b0;
    assign w_unused_tmo = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_go && !flush) w_state_nxt = ST_BUSY;
            ST_BUSY: begin
                if (dbus_ack || w_tmo_hit) w_state_nxt = ST_DONE;
                else if (flush)            w_state_nxt = ST_DRAIN;
            end
            ST_DONE:  if (flush || stall[4] == NOSTOP) w_state_nxt = ST_IDLE;
            ST_DRAIN: begin
                if (dbus_ack)       w_state_nxt = ST_IDLE;
                else if (w_tmo_hit) w_state_nxt = ST_DONE;
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // The request stays up through DRAIN: the slave still owes an ack for it.
    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tmo   <= (w_state_nxt == ST_DONE) && (r_tmo || w_tmo_hit);
            case (r_state)
                ST_IDLE: begin
                    if (w_state_nxt == ST_BUSY) begin
                        r_req   <= 1'b1;
                        r_wr    <= exmem_we;
                        r_addr  <= w_addr_al[BUS_AW-1:0];
                        r_be    <= w_be;
                        r_wdata <= w_wdata_rep;
                    end
                end
                ST_BUSY, ST_DRAIN: begin
                    if (dbus_ack || w_tmo_hit) r_req <= 1'b0;
                    if (r_state == ST_BUSY && dbus_ack) r_rdata <= dbus_rdata;
                    else if (w_tmo_hit)                 r_rdata <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_exccode = EXC_NONE;
        if (w_mis)      mem_exccode = exmem_re ? EXC_ADEL : EXC_ADES;
        else if (w_dbe) mem_exccode = EXC_DBE;
    end

    assign mem_badvaddr  = (w_mis || w_dbe) ? exmem_addr : '0;
    assign mem_wa        = exmem_wa;
    assign mem_wreg      = exmem_wreg & ~w_mis & ~w_dbe;
    assign mem_dreg      = exmem_dreg;
    assign mem_whilo     = exmem_whilo;
    assign mem_hilo      = exmem_hilo;
    assign mem_cp0_we    = exmem_cp0_we;
    assign mem_cp0_waddr = exmem_cp0_waddr;
    assign mem_cp0_wdata = exmem_cp0_wdata;
    assign mem_mreg      = exmem_re & ~w_mis;
    assign mem_dre       = exmem_re ? w_be : '0;
    assign mem_daddr     = exmem_addr;
    assign mem_sign      = exmem_sign;
    assign mem_dm        = (r_state == ST_DONE) ? r_rdata : '0;
    assign stall_req_mem = w_go && (r_state != ST_DONE);

    assign dbus_req   = r_req;
    assign dbus_wr    = r_wr;
    assign dbus_addr  = r_addr;
    assign dbus_be    = r_be;
    assign dbus_wdata = r_wdata;

endmodule

// File: tb/tb_mem_dbus_stage.sv
// Randomized self-checking bench for mem_dbus_stage against a transaction-level model.
module tb_mem_dbus_stage;
    import mem_dbus_stage_pkg::*;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  stall;
    logic        flush, exmem_re, exmem_we, exmem_sign, exmem_wreg, exmem_whilo, exmem_cp0_we;
    logic [1:0]  exmem_size;
    logic [31:0] exmem_addr, exmem_wdata, exmem_dreg, exmem_cp0_wdata;
    logic [4:0]  exmem_wa, exmem_cp0_waddr;
    logic [63:0] exmem_hilo;
    logic [4:0]  mem_wa, mem_cp0_waddr, mem_exccode;
    logic        mem_wreg, mem_whilo, mem_cp0_we, mem_mreg, mem_sign, stall_req_mem;
    logic [31:0] mem_dreg, mem_cp0_wdata, mem_daddr, mem_dm, mem_badvaddr;
    logic [63:0] mem_hilo;
    logic [3:0]  mem_dre, dbus_be;
    logic        dbus_req, dbus_wr, dbus_ack;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_dbus_stage #(.BUS_AW(32), .TIMEOUT_CYCLES(TMO)) dut (
        .cpu_clk_50M(clk), .cpu_rst_n(rst_n), .stall(stall), .flush(flush),
        .exmem_re(exmem_re), .exmem_we(exmem_we), .exmem_size(exmem_size),
        .exmem_sign(exmem_sign), .exmem_addr(exmem_addr), .exmem_wdata(exmem_wdata),
        .exmem_wa(exmem_wa), .exmem_wreg(exmem_wreg), .exmem_dreg(exmem_dreg),
        .exmem_whilo(exmem_whilo), .exmem_hilo(exmem_hilo), .exmem_cp0_we(exmem_cp0_we),
        .exmem_cp0_waddr(exmem_cp0_waddr), .exmem_cp0_wdata(exmem_cp0_wdata),
        .mem_wa(mem_wa), .mem_wreg(mem_wreg), .mem_dreg(mem_dreg), .mem_whilo(mem_whilo),
        .mem_hilo(mem_hilo), .mem_cp0_we(mem_cp0_we), .mem_cp0_waddr(mem_cp0_waddr),
        .mem_cp0_wdata(mem_cp0_wdata), .mem_mreg(mem_mreg), .mem_dre(mem_dre),
        .mem_daddr(mem_daddr), .mem_dm(mem_dm), .mem_sign(mem_sign),
        .mem_exccode(mem_exccode), .mem_badvaddr(mem_badvaddr),
        .stall_req_mem(stall_req_mem), .dbus_req(dbus_req), .dbus_wr(dbus_wr),
        .dbus_addr(dbus_addr), .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
        .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack)
    );

    // Reference model: access width in bytes, and what follows from it.
    function automatic int unsigned nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic misaligned(input logic [1:0] sz, input logic [31:0] a);
        return (a % nbytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
        int unsigned n = nbytes(sz);
        return 4'(((32'd1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] model_rep(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] r;
        int unsigned n = nbytes(sz);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    task automatic cycle_end();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_access();
        exmem_re = 1'b0; exmem_we = 1'b0; flush = 1'b0; stall = '0; dbus_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_access();
        exmem_addr = '0; exmem_size = '0; exmem_wdata = '0; exmem_sign = 1'b0;
        exmem_wreg = 1'b0; dbus_rdata = '0;
        repeat (2) cycle_end();
        @(negedge clk);
        checks++;
        if ({dbus_req, dbus_wr, dbus_addr, dbus_be, dbus_wdata, mem_dm, stall_req_mem} !== '0)
            begin failures++; $display("FAIL reset_outputs req=%b wr=%b addr=%h be=%b wd=%h dm=%h stl=%b expected all 0",
                dbus_req, dbus_wr, dbus_addr, dbus_be, dbus_wdata, mem_dm, stall_req_mem); end
        cycle_end();
        rst_n = 1'b1;
    endtask

    task automatic test_passthrough();
        for (int k = 0; k < 3; k++) begin
            exmem_wa = 5'($urandom); exmem_wreg = 1'($urandom); exmem_dreg = $urandom;
            exmem_whilo = 1'($urandom); exmem_hilo = {$urandom, $urandom};
            exmem_cp0_we = 1'($urandom); exmem_cp0_waddr = 5'($urandom);
            exmem_cp0_wdata = $urandom; exmem_addr = $urandom; exmem_sign = 1'($urandom);
            @(negedge clk);
            checks++;
            if ({mem_wa, mem_wreg, mem_dreg, mem_whilo, mem_hilo, mem_cp0_we, mem_cp0_waddr, mem_cp0_wdata, mem_daddr, mem_sign}
                !== {exmem_wa, exmem_wreg, exmem_dreg, exmem_whilo, exmem_hilo, exmem_cp0_we, exmem_cp0_waddr, exmem_cp0_wdata, exmem_addr, exmem_sign})
                begin failures++; $display("FAIL passthru wa=%h wreg=%b dreg=%h hilo=%h cp0=%h daddr=%h expected wa=%h wreg=%b dreg=%h hilo=%h cp0=%h daddr=%h",
                    mem_wa, mem_wreg, mem_dreg, mem_hilo, mem_cp0_wdata, mem_daddr,
                    exmem_wa, exmem_wreg, exmem_dreg, exmem_hilo, exmem_cp0_wdata, exmem_addr); end
            checks++;
            if ({mem_mreg, mem_dre, mem_exccode, mem_badvaddr, mem_dm, stall_req_mem, dbus_req} !== '0)
                begin failures++; $display("FAIL idle_outputs mreg=%b dre=%b exc=%h bad=%h dm=%h stl=%b req=%b expected all 0",
                    mem_mreg, mem_dre, mem_exccode, mem_badvaddr, mem_dm, stall_req_mem, dbus_req); end
            cycle_end();
        end
    endtask

    // One aligned access: ack arrives in the dly-th request cycle, then stall[4]
    // is held at STOP for `hold` cycles in the result cycle before advancing.
    task automatic do_access(input logic ld, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rd,
                             input int unsigned dly, input int unsigned hold, input string tag);
        logic [3:0]  be  = model_be(sz, a);
        logic [31:0] rep = model_rep(sz, wd);
        int unsigned req_cnt = 0;
        int unsigned stl_cnt = 0;
        exmem_re = ld; exmem_we = !ld; exmem_size = sz; exmem_addr = a;
        exmem_wdata = wd; exmem_wreg = 1'b1; flush = 1'b0;
        for (int unsigned c = 0; c <= dly + 1 + hold; c++) begin
            dbus_ack   = (c == dly);
            dbus_rdata = (c == dly) ? rd : $urandom;
            stall      = (c > dly && c <= dly + hold) ? 6'b010000 : 6'b000000;
            @(negedge clk);
            if (stall_req_mem === 1'b1) stl_cnt++;
            if (dbus_req === 1'b1) req_cnt++;
            checks++;
            if (stall_req_mem !== (c <= dly))
                begin failures++; $display("FAIL %s stall_req c=%0d got=%b exp=%b", tag, c, stall_req_mem, c <= dly); end
            checks++;
            if (dbus_req !== (c >= 1 && c <= dly))
                begin failures++; $display("FAIL %s dbus_req c=%0d got=%b exp=%b", tag, c, dbus_req, c >= 1 && c <= dly); end
            if (c >= 1 && c <= dly) begin
                checks++;
                if ({dbus_addr, dbus_be, dbus_wr, dbus_wdata} !== {a & ~32'h3, be, !ld, rep})
                    begin failures++; $display("FAIL %s bus_fields c=%0d got addr=%h be=%b wr=%b wd=%h exp addr=%h be=%b wr=%b wd=%h",
                        tag, c, dbus_addr, dbus_be, dbus_wr, dbus_wdata, a & ~32'h3, be, !ld, rep); end
            end
            checks++;
            if ({mem_exccode, mem_wreg, mem_dre} !== {EXC_NONE, 1'b1, ld ? be : 4'b0000})
                begin failures++; $display("FAIL %s exc_dre c=%0d got exc=%h wreg=%b dre=%b exp exc=00 wreg=1 dre=%b",
                    tag, c, mem_exccode, mem_wreg, mem_dre, ld ? be : 4'b0000); end
            if (c <= dly || ld) begin
                checks++;
                if (mem_dm !== ((c > dly) ? rd : 32'h0))
                    begin failures++; $display("FAIL %s mem_dm c=%0d got=%h exp=%h", tag, c, mem_dm, (c > dly) ? rd : 32'h0); end
            end
            cycle_end();
        end
        clear_access();
        checks++;
        if (req_cnt != dly || stl_cnt != dly + 1)
            begin failures++; $display("FAIL %s cycle_counts got req=%0d stall=%0d exp req=%0d stall=%0d",
                tag, req_cnt, stl_cnt, dly, dly + 1); end
    endtask

    task automatic test_misalign(input logic ld, input logic [1:0] sz, input logic [31:0] a);
        exmem_re = ld; exmem_we = !ld; exmem_size = sz; exmem_addr = a; exmem_wreg = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if ({dbus_req, stall_req_mem, mem_wreg, mem_mreg, mem_exccode, mem_badvaddr}
                !== {4'b0000, ld ? EXC_ADEL : EXC_ADES, a})
                begin failures++; $display("FAIL misalign a=%h got req=%b stl=%b wreg=%b mreg=%b exc=%h bad=%h exp req=0 stl=0 wreg=0 mreg=0 exc=%h bad=%h",
                    a, dbus_req, stall_req_mem, mem_wreg, mem_mreg, mem_exccode, mem_badvaddr, ld ? EXC_ADEL : EXC_ADES, a); end
            cycle_end();
        end
        clear_access();
    endtask

    task automatic test_flush_idle();
        exmem_re = 1'b1; exmem_size = 2'b10; exmem_addr = 32'h0000_0600; flush = 1'b1;
        cycle_end();
        clear_access();
        @(negedge clk);
        checks++;
        if ({dbus_req, stall_req_mem} !== 2'b00)
            begin failures++; $display("FAIL flush_idle got req=%b stl=%b exp 0 0", dbus_req, stall_req_mem); end
        cycle_end();
    endtask

    task automatic test_flush_busy();
        exmem_re = 1'b1; exmem_we = 1'b0; exmem_size = 2'b10; exmem_addr = 32'h0000_0300;
        cycle_end();
        for (int c = 1; c <= 5; c++) begin
            flush = (c == 2);
            dbus_ack = (c == 4);
            dbus_rdata = 32'hBAD0_BAD0;
            if (c == 3) exmem_addr = 32'h0000_0304;
            if (c == 5) break;
            @(negedge clk);
            checks++;
            if ({dbus_req, mem_dm} !== {1'b1, 32'h0})
                begin failures++; $display("FAIL flush_busy c=%0d got req=%b dm=%h exp req=1 dm=0", c, dbus_req, mem_dm); end
            if (c >= 3) begin
                checks++;
                if (stall_req_mem !== 1'b1)
                    begin failures++; $display("FAIL drain_stall c=%0d got=%b exp=1", c, stall_req_mem); end
            end
            cycle_end();
        end
        clear_access();
        do_access(1'b1, 2'b10, 32'h0000_0304, 32'h0, 32'h1234_5678, 2, 0, "after_drain");
    endtask

    task automatic test_reset_busy();
        exmem_we = 1'b1; exmem_size = 2'b10; exmem_addr = 32'h0000_0400; exmem_wdata = 32'hCAFE_F00D;
        repeat (3) cycle_end();
        rst_n = 1'b0;
        clear_access();
        cycle_end();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({dbus_req, dbus_wr, dbus_addr, dbus_be, dbus_wdata, mem_dm, stall_req_mem} !== '0)
            begin failures++; $display("FAIL reset_busy req=%b wr=%b addr=%h be=%b wd=%h dm=%h stl=%b expected all 0",
                dbus_req, dbus_wr, dbus_addr, dbus_be, dbus_wdata, mem_dm, stall_req_mem); end
        cycle_end();
        do_access(1'b1, 2'b01, 32'h0000_0402, 32'h0, 32'h0000_BEEF, 1, 0, "after_reset");
    endtask

`ifdef DBUS_TIMEOUT_EN
    task automatic test_timeout();
        exmem_re = 1'b1; exmem_size = 2'b10; exmem_addr = 32'h0000_0500; exmem_wreg = 1'b1;
        for (int unsigned c = 0; c <= TMO + 1; c++) begin
            @(negedge clk);
            checks++;
            if (dbus_req !== (c >= 1 && c <= TMO))
                begin failures++; $display("FAIL timeout_req c=%0d got=%b exp=%b", c, dbus_req, c >= 1 && c <= TMO); end
            if (c == TMO + 1) begin
                checks++;
                if ({mem_exccode, mem_badvaddr, mem_wreg, stall_req_mem} !== {EXC_DBE, 32'h0000_0500, 2'b00})
                    begin failures++; $display("FAIL timeout_exc got exc=%h bad=%h wreg=%b stl=%b exp exc=07 bad=00000500 wreg=0 stl=0",
                        mem_exccode, mem_badvaddr, mem_wreg, stall_req_mem); end
            end
            cycle_end();
        end
        clear_access();
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 24; k++) begin
            logic [1:0]  sz = 2'($urandom_range(0, 3));
            logic [31:0] a  = $urandom;
            logic        ld = 1'($urandom_range(0, 1));
            if (misaligned(sz, a)) test_misalign(ld, sz, a);
            else do_access(ld, sz, a, $urandom, $urandom, $urandom_range(1, 3), $urandom_range(0, 2), "random");
        end
    endtask

    initial begin
        stall = '0; flush = 1'b0; dbus_ack = 1'b0;
        exmem_wa = '0; exmem_dreg = '0; exmem_whilo = 1'b0; exmem_hilo = '0;
        exmem_cp0_we = 1'b0; exmem_cp0_waddr = '0; exmem_cp0_wdata = '0;
        test_reset();
        test_passthrough();
        do_access(1'b1, 2'b10, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 3, 0, "word_load");
        do_access(1'b0, 2'b00, 32'h0000_0203, 32'h0000_00A5, 32'h0, 1, 0, "byte_store");
        test_misalign(1'b1, 2'b01, 32'h0000_0101);
        test_misalign(1'b0, 2'b11, 32'h0000_0102);
        do_access(1'b1, 2'b01, 32'h0000_0106, 32'h0, 32'h8765_4321, 2, 2, "done_hold");
        test_flush_idle();
        test_flush_busy();
        test_reset_busy();
`ifdef DBUS_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before the sequence finished");
        $fatal(1);
    end

endmodule
